// File: rtl/bf_pkg.sv
// Shared Bellman-Ford constants and WorkingMemory types.
package bf_pkg;

    localparam int unsigned DEF_NREQ = 4;
    localparam int unsigned WM_AW    = 13;
    localparam int unsigned WM_DW    = 128;
    localparam int unsigned DEF_CW   = 16;

    typedef logic [WM_AW-1:0] wm_addr_t;
    typedef logic [WM_DW-1:0] wm_data_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first valid requester at or after ptr.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    found,
    output logic [$clog2(NREQ)-1:0] winner
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] idx;

    // Walk from farthest to nearest so the closest valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % int'(NREQ));
            if (valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/wm_write_arbiter.sv
// Round-robin arbiter for the WorkingMemory write port, with RAW hazard
// flags and a per-pass saturating count of accepted writes.
module wm_write_arbiter
    import bf_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned AW   = WM_AW,
    parameter int unsigned DW   = WM_DW,
    parameter int unsigned CW   = DEF_CW
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    hold,
    input  logic                    pass_clear,
    input  logic [AW-1:0]           rd_addr1,
    input  logic [AW-1:0]           rd_addr2,
    output logic                    rd_hazard1,
    output logic                    rd_hazard2,
    output logic                    WMWE,
    output logic [AW-1:0]           WMWAR,
    output logic [DW-1:0]           WMWDR,
    output logic [CW-1:0]           wr_count,
    output logic [$clog2(NREQ)-1:0] grant_idx
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic          found;
    logic          accept;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid  (req_valid),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    // The granted requester is always valid, so a grant is an accept.
    assign accept = found && !hold;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Payload mux for the winning requester.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == IW'(i)) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            WMWE      <= 1'b0;
            WMWAR     <= '0;
            WMWDR     <= '0;
            grant_idx <= '0;
            ptr       <= '0;
            wr_count  <= '0;
        end else begin
            WMWE <= accept;
            if (accept) begin
                WMWAR     <= sel_addr;
                WMWDR     <= sel_data;
                grant_idx <= winner;
                ptr       <= (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
            end
            if (pass_clear) begin
                wr_count <= accept ? CW'(1) : '0;
            end else if (accept && wr_count != CNT_MAX) begin
                wr_count <= wr_count + CW'(1);
            end
        end
    end

    // A read issued while a write is registered returns pre-write data.
    assign rd_hazard1 = WMWE && (WMWAR == rd_addr1);
    assign rd_hazard2 = WMWE && (WMWAR == rd_addr2);

endmodule

// File: tb/tb_wm_write_arbiter.sv
// Bench for wm_write_arbiter: directed table, corner sequences and random
// traffic against a behavioural model of the arbitration rules.
module tb_wm_write_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 13;
    localparam int DW   = 128;
    localparam int CW   = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              hold;
    logic              pass_clear;
    logic [AW-1:0]     rd_addr1;
    logic [AW-1:0]     rd_addr2;
    logic              rd_hazard1;
    logic              rd_hazard2;
    logic              WMWE;
    logic [AW-1:0]     WMWAR;
    logic [DW-1:0]     WMWDR;
    logic [CW-1:0]     wr_count;
    logic [1:0]        grant_idx;

    logic [AW-1:0] a [NREQ];
    logic [DW-1:0] d [NREQ];

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic          m_we;
    logic [AW-1:0] m_war;
    logic [DW-1:0] m_wdr;
    int            m_gidx;
    int            m_ptr;
    int            m_cnt;

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_data[i*DW +: DW] = d[i];
        end
    end

    wm_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .hold       (hold),
        .pass_clear (pass_clear),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_hazard1 (rd_hazard1),
        .rd_hazard2 (rd_hazard2),
        .WMWE       (WMWE),
        .WMWAR      (WMWAR),
        .WMWDR      (WMWDR),
        .wr_count   (wr_count),
        .grant_idx  (grant_idx)
    );

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Inputs are set at a falling edge; check combinational outputs, advance
    // one rising edge, then check registered outputs against the model.
    task automatic step();
        int              w;
        logic [NREQ-1:0] er;
        logic            acc;
        logic            n_we;
        logic [AW-1:0]   n_war;
        logic [DW-1:0]   n_wdr;
        int              n_gidx, n_ptr, n_cnt;
        #1;
        w  = pick(req_valid, m_ptr);
        er = '0;
        acc = (w >= 0) && !hold;
        if (acc) er[w] = 1'b1;
        chk("req_ready", 128'(req_ready), 128'(er));
        chk("rd_hazard1", 128'(rd_hazard1), 128'(m_we && (m_war == rd_addr1)));
        chk("rd_hazard2", 128'(rd_hazard2), 128'(m_we && (m_war == rd_addr2)));
        n_we = acc; n_war = m_war; n_wdr = m_wdr; n_gidx = m_gidx; n_ptr = m_ptr; n_cnt = m_cnt;
        if (reset) begin
            n_we = 1'b0; n_war = '0; n_wdr = '0; n_gidx = 0; n_ptr = 0; n_cnt = 0;
        end else begin
            if (acc) begin
                n_war = a[w]; n_wdr = d[w]; n_gidx = w; n_ptr = (w + 1) % NREQ;
            end
            if (pass_clear) n_cnt = acc ? 1 : 0;
            else if (acc && m_cnt < 65535) n_cnt = m_cnt + 1;
        end
        @(posedge clock);
        @(negedge clock);
        m_we = n_we; m_war = n_war; m_wdr = n_wdr; m_gidx = n_gidx; m_ptr = n_ptr; m_cnt = n_cnt;
        chk("WMWE", 128'(WMWE), 128'(m_we));
        chk("WMWAR", 128'(WMWAR), 128'(m_war));
        chk("WMWDR", 128'(WMWDR), 128'(m_wdr));
        chk("grant_idx", 128'(grant_idx), 128'(m_gidx));
        chk("wr_count", 128'(wr_count), 128'(m_cnt));
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; hold = 1'b0; pass_clear = 1'b0;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       hold;
        logic       pclr;
        logic [3:0] exp_ready;
        logic       exp_we;
        logic [1:0] exp_gidx;
        int         exp_cnt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        reset = 1'b1; req_valid = '0; hold = 1'b0; pass_clear = 1'b0;
        rd_addr1 = '0; rd_addr2 = '0;
        m_we = 1'b0; m_war = '0; m_wdr = '0; m_gidx = 0; m_ptr = 0; m_cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = AW'(13'h100 + i);
            d[i] = {32'hDEAD0000 + 32'(i), 32'h1111 * 32'(i + 1), 32'h0, 32'(i)};
        end
        @(negedge clock);

        // Reset state
        chk("reset WMWE", 128'(WMWE), 128'(0));
        chk("reset WMWAR", 128'(WMWAR), 128'(0));
        chk("reset WMWDR", 128'(WMWDR), 128'(0));
        chk("reset grant_idx", 128'(grant_idx), 128'(0));
        chk("reset wr_count", 128'(wr_count), 128'(0));
        chk("reset req_ready", 128'(req_ready), 128'(0));
        chk("reset rd_hazard1", 128'(rd_hazard1), 128'(0));
        reset = 1'b0;

        // Directed table from reset: rotation, hold, pass_clear, wrap
        tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1};
        tbl[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 2};
        tbl[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 3};
        tbl[3]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 4};
        tbl[4]  = '{4'b1010, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 4};
        tbl[5]  = '{4'b1010, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 4};
        tbl[6]  = '{4'b1010, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 4};
        tbl[7]  = '{4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 5};
        tbl[8]  = '{4'b1010, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 6};
        tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 6};
        tbl[10] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1};
        tbl[11] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 0};
        tbl[12] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1};
        tbl[13] = '{4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 2};
        do_reset();
        for (int v = 0; v < 14; v++) begin
            req_valid = tbl[v].valid; hold = tbl[v].hold; pass_clear = tbl[v].pclr;
            #1;
            chk($sformatf("tbl%0d ready", v), 128'(req_ready), 128'(tbl[v].exp_ready));
            step();
            chk($sformatf("tbl%0d WMWE", v), 128'(WMWE), 128'(tbl[v].exp_we));
            chk($sformatf("tbl%0d grant_idx", v), 128'(grant_idx), 128'(tbl[v].exp_gidx));
            chk($sformatf("tbl%0d wr_count", v), 128'(wr_count), 128'(tbl[v].exp_cnt));
            if (tbl[v].exp_we) chk($sformatf("tbl%0d WMWAR", v), 128'(WMWAR), 128'(a[tbl[v].exp_gidx]));
        end
        pass_clear = 1'b0; hold = 1'b0;

        // Single requester 2 writes addr 5, data A5
        do_reset();
        a[2] = 13'h0005; d[2] = 128'hA5;
        req_valid = 4'b0100;
        #1 chk("single ready", 128'(req_ready), 128'(4'b0100));
        step();
        req_valid = '0;
        chk("single WMWE", 128'(WMWE), 128'(1));
        chk("single WMWAR", 128'(WMWAR), 128'(13'h0005));
        chk("single WMWDR", 128'(WMWDR), 128'hA5);
        chk("single grant_idx", 128'(grant_idx), 128'(2));
        chk("single wr_count", 128'(wr_count), 128'(1));

        // Read-after-write hazard on addr 0x40
        a[0] = 13'h0040;
        req_valid = 4'b0001;
        step();
        req_valid = '0; rd_addr1 = 13'h0040; rd_addr2 = 13'h0041;
        #1;
        chk("hazard1 set", 128'(rd_hazard1), 128'(1));
        chk("hazard2 clear", 128'(rd_hazard2), 128'(0));
        step();
        chk("hazard1 drained", 128'(rd_hazard1), 128'(0));
        chk("hazard2 drained", 128'(rd_hazard2), 128'(0));

        // Reset the cycle after an accept drops the in-flight write
        req_valid = 4'b0010;
        step();
        reset = 1'b1; req_valid = '0;
        step();
        reset = 1'b0;
        chk("rst WMWE", 128'(WMWE), 128'(0));
        chk("rst wr_count", 128'(wr_count), 128'(0));
        req_valid = 4'b1111;
        #1 chk("rst ptr ready", 128'(req_ready), 128'(4'b0001));
        step();
        chk("rst ptr grant", 128'(grant_idx), 128'(0));

        // Counter saturation
        do_reset();
        req_valid = 4'b0001;
        for (int i = 0; i < 65535; i++) step();
        chk("sat preload", 128'(wr_count), 128'(16'hFFFF));
        step();
        chk("sat hold", 128'(wr_count), 128'(16'hFFFF));
        pass_clear = 1'b1;
        step();
        chk("sat clear+accept", 128'(wr_count), 128'(1));
        pass_clear = 1'b0;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 99) == 0);
            req_valid  = 4'($urandom);
            hold       = ($urandom_range(0, 7) == 0);
            pass_clear = ($urandom_range(0, 15) == 0);
            rd_addr1   = AW'($urandom_range(0, 7));
            rd_addr2   = AW'($urandom_range(0, 7));
            for (int i = 0; i < NREQ; i++) begin
                a[i] = AW'($urandom_range(0, 7));
                d[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
